systolic_stream_ctrl: RTL



---
 rtl/systolic_pkg.sv | 19 +
 rtl/lane_delay.sv | 36 +++
 rtl/systolic_stream_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic stream controller: job states,
// default lane width and the row-counter width rule.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;

  // Counters must hold the value max_count itself, not only max_count-1.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/lane_delay.sv
// Per-lane delay line used for X skew and Y deskew; DEPTH=0 degenerates
// to a plain wire so the last Y lane and X lane 0 add no extra cycle.
module lane_delay
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_d
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_d      = i_d;
    end else begin : g_shift
      logic [DATA_WIDTH-1:0] r_sr [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
        end else begin
          r_sr[0] <= i_d;
          for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
        end
      end

      assign o_d = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_stream_ctrl.sv
// Job-level streaming controller for a weight-stationary systolic array:
// accepts M rows, skews them onto arr_x, deskews arr_y and tags aligned rows.
module systolic_stream_ctrl
  import systolic_pkg::*;
#(
  parameter int M          = 5,
  parameter int N          = 3,
  parameter int K          = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ARRAY_LAT  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH*N-1:0] in_data,
  output logic [DATA_WIDTH*N-1:0] arr_x,
  input  logic [DATA_WIDTH*K-1:0] arr_y,
  output logic                    out_valid,
  output logic [DATA_WIDTH*K-1:0] out_data
);

  localparam int CW = cnt_width(M);
  // One register stage ahead of the tag chain mirrors the lane-0 X register.
  localparam int L  = ARRAY_LAT + K - 1;

  state_t                  r_state;
  state_t                  w_state_n;
  logic [CW-1:0]           r_rows_in;
  logic [CW-1:0]           r_rows_out;
  logic                    w_accept;
  logic                    w_last_in;
  logic                    w_last_out;
  logic [DATA_WIDTH*N-1:0] r_x_p0;
  logic                    r_vld_p0;
  logic [L-1:0]            r_vld_sr;

  assign w_accept   = in_valid & in_ready;
  assign w_last_in  = (r_rows_in == CW'(M - 1));
  assign w_last_out = (r_rows_out == CW'(M - 1));
  assign out_valid  = r_vld_sr[L-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    in_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_n = FEED;
      end
      FEED: begin
        busy     = 1'b1;
        in_ready = (r_rows_in < CW'(M));
        if (w_accept && w_last_in) w_state_n = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_valid && w_last_out) w_state_n = DONE;
      end
      DONE: begin
        done      = 1'b1;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Job counters restart every time the controller returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rows_in  <= '0;
      r_rows_out <= '0;
    end else if (r_state == IDLE) begin
      r_rows_in  <= '0;
      r_rows_out <= '0;
    end else begin
      if (w_accept)          r_rows_in  <= r_rows_in + CW'(1);
      if (out_valid && busy) r_rows_out <= r_rows_out + CW'(1);
    end
  end

  // ---- p0: input row register; bubbles inject zeros into the array ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x_p0   <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_x_p0   <= w_accept ? in_data : '0;
      r_vld_p0 <= w_accept;
    end
  end

  // ---- valid tag: follows the row through array latency plus deskew ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr[0] <= r_vld_p0;
      for (int k = 1; k < L; k++) r_vld_sr[k] <= r_vld_sr[k-1];
    end
  end

  // ---- X skew: lane i trails lane 0 by i cycles ----
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_xlane
      lane_delay #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (gi)
      ) u_xdly (
        .clk (clk),
        .rst (rst),
        .i_d (r_x_p0[gi*DATA_WIDTH +: DATA_WIDTH]),
        .o_d (arr_x[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  // ---- Y deskew: early lanes wait so every lane lines up with lane K-1 ----
  generate
    for (genvar gj = 0; gj < K; gj++) begin : g_ylane
      lane_delay #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (K - 1 - gj)
      ) u_ydly (
        .clk (clk),
        .rst (rst),
        .i_d (arr_y[gj*DATA_WIDTH +: DATA_WIDTH]),
        .o_d (out_data[gj*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule
